// File: rtl/muldiv_ctrl.sv
// ============================================================================
// muldiv_ctrl
// ----------------------------------------------------------------------------
// HI/LO and multiply/divide sequencing for a MIPS-style EXE stage.
//
// The block accepts one multiply, divide or move-to-HI/LO operation per cycle.
// It launches it on an external multiplier or divider and holds the pipeline
// until the matching result comes back. It owns the architectural HI and LO
// registers. At most one operation is in flight at a time. A watchdog aborts
// a wait that never sees its completion.
//
// Ports
//   clk           : sole clock, all state changes on the rising edge
//   resetn        : asynchronous active-low reset
//   op_valid      : an operation is present in EXE this cycle
//   op_type[2:0]  : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, else NOP
//   src_a, src_b  : rs / rt operands
//   flush         : cancel whatever is in flight, no HI/LO write this edge
//   mul_en        : one-cycle launch pulse to the multiplier
//   mul_signed    : signed multiply (held with the operands)
//   mul_x, mul_y  : multiplier operands, registered at launch
//   div_en        : one-cycle launch pulse to the divider
//   div_signed    : signed divide (held with the operands)
//   div_x, div_y  : divider operands, registered at launch
//   mul_busy      : multiplier still working on an older operation
//   mul_complete  : multiplier result valid this cycle
//   mul_result    : 64-bit product
//   div_complete  : divider result valid this cycle
//   div_q, div_r  : quotient and remainder
//   stall         : combinational pipeline freeze
//   hi, lo        : architectural HI / LO
//   wdog_err      : one-cycle pulse when a wait is aborted
// ============================================================================
module muldiv_ctrl #(
    parameter int WDOG = 63
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        mul_en,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        div_en,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic        mul_busy,
    input  logic        mul_complete,
    input  logic [63:0] mul_result,
    input  logic        div_complete,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wdog_err
);

    // The counter only has to hold 0 .. WDOG-1.
    localparam int CW = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic div_by_zero;

    logic launch_mul;
    logic launch_div;
    logic load_mul;
    logic load_div;
    logic wr_hi;
    logic wr_lo;
    logic wdog_fire;
    logic cnt_inc;
    logic stall_raw;

    // Operation decode, qualified by op_valid.
    always_comb begin
        is_mul      = op_valid && ((op_type == OP_MULT) || (op_type == OP_MULTU));
        is_div      = op_valid && ((op_type == OP_DIV)  || (op_type == OP_DIVU));
        is_mthi     = op_valid && (op_type == OP_MTHI);
        is_mtlo     = op_valid && (op_type == OP_MTLO);
        div_by_zero = (src_b == 32'd0);
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode.
    // flush is checked first in every state, so it beats launches,
    // completions, watchdog aborts and moves to HI/LO.
    // A divide by zero is dropped. It does not launch, stall or write.
    // A completion from the unit we are not waiting on is ignored.
    always_comb begin
        next_state = state;
        stall_raw  = 1'b0;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        wdog_fire  = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (is_mul) begin
                    // An older multiply still owns the unit, so hold this op
                    // in EXE until the unit drains.
                    stall_raw = 1'b1;
                    if (!mul_busy) begin
                        launch_mul = 1'b1;
                        next_state = MUL_WAIT;
                    end
                end else if (is_div) begin
                    if (!div_by_zero) begin
                        stall_raw  = 1'b1;
                        launch_div = 1'b1;
                        next_state = DIV_WAIT;
                    end
                end else if (is_mthi) begin
                    wr_hi = 1'b1;
                end else if (is_mtlo) begin
                    wr_lo = 1'b1;
                end
            end

            MUL_WAIT: begin
                stall_raw = !mul_complete;
                if (flush) begin
                    next_state = IDLE;
                end else if (mul_complete) begin
                    load_mul   = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == WDOG_LAST) begin
                    wdog_fire  = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            DIV_WAIT: begin
                stall_raw = !div_complete;
                if (flush) begin
                    next_state = IDLE;
                end else if (div_complete) begin
                    load_div   = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == WDOG_LAST) begin
                    wdog_fire  = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // stall is gated by resetn because the decode above looks at live inputs.
    // Without the gate, an op sitting in EXE during reset could show a stall.
    assign stall = stall_raw & resetn;

    // Watchdog counter.
    // The counter is zero on entry to a wait state. It advances only while
    // the wait continues. Every other path, including the abort itself,
    // returns it to zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (cnt_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Launch pulses and the abort pulse are registered.
    // Each enable goes high in the same cycle that its operand registers show
    // the new values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_en   <= 1'b0;
            div_en   <= 1'b0;
            wdog_err <= 1'b0;
        end else begin
            mul_en   <= launch_mul;
            div_en   <= launch_div;
            wdog_err <= wdog_fire;
        end
    end

    // Operand registers.
    // They are captured only on a launch and held stable until the next
    // launch, so the unit can resample them at any time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_signed <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            div_signed <= 1'b0;
            div_x      <= '0;
            div_y      <= '0;
        end else begin
            if (launch_mul) begin
                mul_signed <= ~op_type[0];
                mul_x      <= src_a;
                mul_y      <= src_b;
            end
            if (launch_div) begin
                div_signed <= ~op_type[0];
                div_x      <= src_a;
                div_y      <= src_b;
            end
        end
    end

    // Architectural HI/LO.
    // The decode allows at most one writer per cycle. A divide puts the
    // quotient in LO and the remainder in HI.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (load_mul) begin
            hi <= mul_result[63:32];
            lo <= mul_result[31:0];
        end else if (load_div) begin
            hi <= div_r;
            lo <= div_q;
        end else if (wr_hi) begin
            hi <= src_a;
        end else if (wr_lo) begin
            lo <= src_a;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// tb_muldiv_ctrl
// ----------------------------------------------------------------------------
// Directed bench for muldiv_ctrl.
//
// The bench drives the multiplier and divider handshakes by hand. Expected
// HI/LO values are worked out by hand for each vector.
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        mul_en;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        mul_busy;
    logic        mul_complete;
    logic [63:0] mul_result;
    logic        div_complete;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wdog_err;

    int vec_count;
    int miscompares;
    int stall_cycles;
    int en_cycles;
    int waited;
    logic fired;

    muldiv_ctrl #(.WDOG(63)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .mul_en       (mul_en),
        .mul_signed   (mul_signed),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .div_x        (div_x),
        .div_y        (div_y),
        .mul_busy     (mul_busy),
        .mul_complete (mul_complete),
        .mul_result   (mul_result),
        .div_complete (div_complete),
        .div_q        (div_q),
        .div_r        (div_r),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .wdog_err     (wdog_err)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. It counts every vector and reports misses.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one EXE-stage operation.
    task automatic applyStimulus(input logic v, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        op_type  = t;
        src_a    = a;
        src_b    = b;
    endtask

    // Inputs change on the falling edge. Outputs are sampled 1 unit later.
    task automatic nextCycle;
        @(negedge clk);
    endtask

    initial begin
        vec_count    = 0;
        miscompares  = 0;
        resetn       = 1'b0;
        flush        = 1'b0;
        mul_busy     = 1'b0;
        mul_complete = 1'b0;
        mul_result   = '0;
        div_complete = 1'b0;
        div_q        = '0;
        div_r        = '0;
        // A multiply sitting in EXE during reset must not show a stall.
        applyStimulus(1'b1, 3'd0, 32'h1234_5678, 32'h9);
        #7;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_mul_en", mul_en, 0);
        checkOutput("rst_div_en", div_en, 0);
        checkOutput("rst_wdog", wdog_err, 0);

        nextCycle;
        resetn = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);

        // MULTU 0xFFFFFFFF * 2. The result arrives three cycles after launch.
        stall_cycles = 0;
        en_cycles    = 0;
        nextCycle;
        applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2);
        #1;
        stall_cycles += int'(stall);
        en_cycles    += int'(mul_en);
        checkOutput("multu_launch_stall", stall, 1);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        stall_cycles += int'(stall);
        en_cycles    += int'(mul_en);
        checkOutput("multu_x", mul_x, 32'hFFFF_FFFF);
        checkOutput("multu_y", mul_y, 32'h2);
        checkOutput("multu_signed", mul_signed, 0);
        nextCycle;
        #1;
        stall_cycles += int'(stall);
        en_cycles    += int'(mul_en);
        nextCycle;
        mul_complete = 1'b1;
        mul_result   = 64'h0000_0001_FFFF_FFFE;
        #1;
        stall_cycles += int'(stall);
        en_cycles    += int'(mul_en);
        nextCycle;
        mul_complete = 1'b0;
        #1;
        checkOutput("multu_stall_cycles", stall_cycles, 3);
        checkOutput("multu_en_cycles", en_cycles, 1);
        checkOutput("multu_hi", hi, 32'h0000_0001);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

        // MULT 0xFFFFFFFF * 3, which is -3.
        nextCycle;
        applyStimulus(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h3);
        #1;
        checkOutput("mult_launch_stall", stall, 1);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        mul_complete = 1'b1;
        mul_result   = 64'hFFFF_FFFF_FFFF_FFFD;
        #1;
        checkOutput("mult_en", mul_en, 1);
        checkOutput("mult_signed", mul_signed, 1);
        checkOutput("mult_complete_stall", stall, 0);
        nextCycle;
        mul_complete = 1'b0;
        #1;
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFD);

        // A completion that arrives while idle is ignored.
        nextCycle;
        mul_complete = 1'b1;
        mul_result   = 64'h1234_5678_9ABC_DEF0;
        nextCycle;
        mul_complete = 1'b0;
        #1;
        checkOutput("idle_complete_hi", hi, 32'hFFFF_FFFF);
        checkOutput("idle_complete_lo", lo, 32'hFFFF_FFFD);

        // DIV 7 / -2. A stray mul_complete arrives during the wait and is
        // ignored.
        nextCycle;
        applyStimulus(1'b1, 3'd2, 32'h7, 32'hFFFF_FFFE);
        #1;
        checkOutput("div_launch_stall", stall, 1);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        mul_complete = 1'b1;
        mul_result   = 64'hAAAA_AAAA_BBBB_BBBB;
        #1;
        checkOutput("div_en", div_en, 1);
        checkOutput("div_signed", div_signed, 1);
        checkOutput("div_x", div_x, 32'h7);
        checkOutput("div_y", div_y, 32'hFFFF_FFFE);
        checkOutput("div_other_complete_stall", stall, 1);
        nextCycle;
        mul_complete = 1'b0;
        div_complete = 1'b1;
        div_q        = 32'hFFFF_FFFD;
        div_r        = 32'h1;
        #1;
        checkOutput("div_complete_stall", stall, 0);
        nextCycle;
        div_complete = 1'b0;
        #1;
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'h0000_0001);

        // DIV 5 / 0 does nothing and does not stall.
        nextCycle;
        applyStimulus(1'b1, 3'd2, 32'h5, 32'h0);
        #1;
        checkOutput("div0_stall", stall, 0);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checkOutput("div0_en", div_en, 0);
        checkOutput("div0_hi", hi, 32'h1);
        checkOutput("div0_lo", lo, 32'hFFFF_FFFD);

        // MTHI / MTLO.
        nextCycle;
        applyStimulus(1'b1, 3'd4, 32'hA5A5_A5A5, 32'h0);
        #1;
        checkOutput("mthi_stall", stall, 0);
        nextCycle;
        applyStimulus(1'b1, 3'd5, 32'h5A5A_5A5A, 32'h0);
        #1;
        checkOutput("mthi_hi", hi, 32'hA5A5_A5A5);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checkOutput("mtlo_lo", lo, 32'h5A5A_5A5A);

        // A flushed MTHI does not write.
        nextCycle;
        applyStimulus(1'b1, 3'd4, 32'hDEAD_BEEF, 32'h0);
        flush = 1'b1;
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        flush = 1'b0;
        #1;
        checkOutput("flush_mthi_hi", hi, 32'hA5A5_A5A5);

        // flush arrives in the same cycle as mul_complete. The next MULT then
        // drains behind mul_busy.
        nextCycle;
        applyStimulus(1'b1, 3'd1, 32'h3, 32'h4);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        mul_complete = 1'b1;
        mul_result   = 64'h0000_0000_0000_000C;
        flush        = 1'b1;
        #1;
        checkOutput("flush_complete_stall", stall, 0);
        nextCycle;
        mul_complete = 1'b0;
        flush        = 1'b0;
        mul_busy     = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'h3, 32'h4);
        #1;
        checkOutput("flush_hi_kept", hi, 32'hA5A5_A5A5);
        checkOutput("flush_lo_kept", lo, 32'h5A5A_5A5A);
        checkOutput("drain_stall", stall, 1);
        nextCycle;
        #1;
        checkOutput("drain_no_launch", mul_en, 0);
        checkOutput("drain_stall_held", stall, 1);
        nextCycle;
        mul_busy = 1'b0;
        #1;
        checkOutput("drain_release_stall", stall, 1);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        mul_complete = 1'b1;
        mul_result   = 64'h0000_0000_0000_000C;
        #1;
        checkOutput("drain_launch_en", mul_en, 1);
        nextCycle;
        mul_complete = 1'b0;
        #1;
        checkOutput("drain_hi", hi, 32'h0);
        checkOutput("drain_lo", lo, 32'hC);

        // The watchdog fires when div_complete never arrives.
        nextCycle;
        applyStimulus(1'b1, 3'd3, 32'h8, 32'h2);
        #1;
        checkOutput("wdog_launch_stall", stall, 1);
        waited = 0;
        fired  = 1'b0;
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 200 && !fired; i++) begin
            if (wdog_err) begin
                fired = 1'b1;
            end else begin
                if (stall) waited++;
                nextCycle;
                #1;
            end
        end
        checkOutput("wdog_fired", fired, 1);
        checkOutput("wdog_wait_cycles", waited, 63);
        checkOutput("wdog_stall_drop", stall, 0);
        nextCycle;
        #1;
        checkOutput("wdog_pulse_width", wdog_err, 0);
        checkOutput("wdog_hi", hi, 32'h0);
        checkOutput("wdog_lo", lo, 32'hC);

        // Reset during MUL_WAIT, followed by a stale completion.
        nextCycle;
        applyStimulus(1'b1, 3'd1, 32'h2, 32'h3);
        nextCycle;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
        #1;
        checkOutput("rstmid_en", mul_en, 1);
        resetn = 1'b0;
        #1;
        checkOutput("rstmid_lo", lo, 32'h0);
        checkOutput("rstmid_stall", stall, 0);
        checkOutput("rstmid_mul_en", mul_en, 0);
        nextCycle;
        resetn = 1'b1;
        nextCycle;
        mul_complete = 1'b1;
        mul_result   = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkOutput("stale_stall", stall, 0);
        nextCycle;
        mul_complete = 1'b0;
        #1;
        checkOutput("stale_hi", hi, 32'h0);
        checkOutput("stale_lo", lo, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
